fetch_queue: RTL and testbench

- Decoupling instruction queue between instruction fetch and instruction decode in the pipelined core.
- Fetch pushes {pc, instruction} pairs and decode pops them, so fetch keeps running while decode stalls.
- Branch resolution flushes stale entries through a synchronous flush.
- Storage is a circular buffer with first-word-fall-through output.

---
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between instruction fetch and decode.
// Circular buffer of {pc, instr} entries with first-word-fall-through output,
// synchronous highest-priority flush and an explicit occupancy count.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, the incoming
// entry is presented on out_* in the same cycle and, if consumed, never stored.
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass;

    // Status, handshake and FWFT output selection.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        in_ready  = !full;
        out_valid = !empty;
        out_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];
        out_instr = empty ? '0 : instr_mem_q[rd_ptr_q];
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass    = empty && in_valid && !flush;
        if (bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
`else
        bypass    = 1'b0;
`endif
        // A bypassed entry taken by decode is consumed without being stored.
        pop  = !flush && !empty && out_ready;
        push = !flush && in_valid && !full && !(bypass && out_ready);
    end

    // Pointer and occupancy next-state; flush overrides any transfer.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// checked by a queue-based reference model and a negedge monitor.
module tb_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [CW-1:0]      count;

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    ent_t exp_q[$];
    int   model_cnt;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of accepted entries plus its size.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_cnt <= 0;
            exp_q.delete();
        end else if (flush) begin
            model_cnt <= 0;
            exp_q.delete();
        end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
            if (in_valid && model_cnt < DEPTH && !(model_cnt == 0 && out_ready))
`else
            if (in_valid && model_cnt < DEPTH)
`endif
                exp_q.push_back(ent_t'{pc: in_pc, instr: in_instr});
            model_cnt <= model_cnt
                       + ((in_valid && model_cnt < DEPTH
`ifdef FETCH_QUEUE_BYPASS_EN
                           && !(model_cnt == 0 && out_ready)
`endif
                          ) ? 1 : 0)
                       - ((model_cnt != 0 && out_ready) ? 1 : 0);
        end
    end

    // Monitor: compares DUT outputs against the model away from the clock edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 64'(count), 64'(model_cnt));
            chk("in_ready", 64'(in_ready), 64'(model_cnt != DEPTH));
            if (model_cnt != 0) begin
                chk("out_valid", 64'(out_valid), 64'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: DUT head pc %0h but no entry expected", out_pc);
                end else begin
                    chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
                    chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
                    if (out_ready && !flush) void'(exp_q.pop_front());
                end
`ifdef FETCH_QUEUE_BYPASS_EN
            end else if (in_valid && !flush) begin
                chk("byp_valid", 64'(out_valid), 64'd1);
                chk("byp_pc", 64'(out_pc), 64'(in_pc));
                chk("byp_instr", 64'(out_instr), 64'(in_instr));
`endif
            end else begin
                chk("idle_valid", 64'(out_valid), 64'd0);
                chk("idle_pc", 64'(out_pc), 64'd0);
                chk("idle_instr", 64'(out_instr), 64'd0);
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit rdy, input bit fl);
        in_valid  = v;
        in_pc     = v ? pc : 'x;
        in_instr  = v ? ins : 'x;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit rdy, input bit fl);
        drive(v, pc, ins, rdy, fl);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] next_pc;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, '0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_pc", 64'(out_pc), 64'd0);

        // Fill and drain.
        for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 32'h1000 + 32'(i), 0, 0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        cyc(1, 32'h10, 32'h1004, 0, 0);
        chk("refused_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) cyc(0, '0, '0, 1, 0);
        chk("drained_valid", 64'(out_valid), 64'd0);

        // Full with simultaneous push attempt and pop.
        for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 32'h2000 + 32'(i), 0, 0);
        cyc(1, 32'h10, 32'h2004, 1, 0);
        chk("fp_count", 64'(count), 64'd3);
        chk("fp_ready", 64'(in_ready), 64'd1);
        cyc(1, 32'h10, 32'h2004, 0, 0);
        chk("fp_accept", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) cyc(0, '0, '0, 1, 0);

        // Back-to-back push/pop across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 32'h100 + 32'(i * 4), 32'h13 + 32'(i), 1, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
            chk("wrap_count", 64'(count), 64'd0);
`else
            chk("wrap_count", 64'(count), 64'd1);
`endif
        end
        cyc(0, '0, '0, 1, 0);

        // Flush beats a simultaneous push and pop.
        cyc(1, 32'h20, 32'h3000, 0, 0);
        cyc(1, 32'h24, 32'h3001, 0, 0);
        chk("pre_flush", 64'(count), 64'd2);
        cyc(1, 32'h28, 32'h3002, 1, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        cyc(1, 32'h40, 32'h3003, 0, 0);
        chk("post_flush_pc", 64'(out_pc), 64'h40);
        cyc(0, '0, '0, 1, 0);

        // Empty-queue latency (bypass versus registered path).
        drive(1, 32'h80, 32'h4000, 1, 0);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_same_valid", 64'(out_valid), 64'd1);
        chk("byp_same_pc", 64'(out_pc), 64'h80);
`else
        chk("nobyp_same_valid", 64'(out_valid), 64'd0);
`endif
        @(posedge clk);
        #1;
        drive(0, '0, '0, 1, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_count", 64'(count), 64'd0);
`else
        chk("nobyp_count", 64'(count), 64'd1);
        chk("nobyp_pc", 64'(out_pc), 64'h80);
`endif
        cyc(0, '0, '0, 1, 0);

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 3; i++) cyc(1, 32'h200 + 32'(i * 4), 32'h5000 + 32'(i), 0, 0);
        chk("pre_rst_count", 64'(count), 64'd3);
        drive(0, '0, '0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_pc", 64'(out_pc), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic.
        next_pc = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), next_pc, $urandom,
                ($urandom_range(0, 3) != 0) ^ (i >= 300 && i < 400),
                $urandom_range(0, 24) == 0);
            next_pc = next_pc + 32'd4;
        end
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, '0, '0, 1, 0);
        chk("final_count", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
